// File: rtl/reg_file.sv
// reg_file: 32-entry x 32-bit register file for the single-cycle MIPS datapath.
//
// Two combinational read ports and one synchronous write port. Register 0 is
// hardwired to zero: writes to it are dropped and reads of it return 0.
//
// Optional feature: define REGFILE_BYPASS_EN to forward an in-flight write to a
// read port addressing the same register in the same cycle (before the edge).
// Without it, a read of the register being written shows the old value.
//
// Ports:
//   clock        - system clock, all state changes on the rising edge
//   reset        - synchronous active-high clear of every register
//   writeEnable  - write writeData to writeAddress on the rising edge
//   readAddress1 - read port 1 address (rs)
//   readAddress2 - read port 2 address (rt)
//   writeAddress - destination register (rd/rt)
//   writeData    - data to write
//   read1        - contents of register readAddress1
//   read2        - contents of register readAddress2
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] readAddress1,
  input  logic [ADDR_WIDTH-1:0] readAddress2,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] read1,
  output logic [DATA_WIDTH-1:0] read2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 is never written after reset and is masked on read, so synthesis
  // can trim it away.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic writeValid;
  assign writeValid = writeEnable && (writeAddress != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeValid) begin
      regs[writeAddress] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward only writes that will actually land on the next edge.
  logic bypassActive;
  assign bypassActive = writeValid && !reset;
`endif

  always_comb begin
    read1 = '0;
    if (readAddress1 != '0) begin
      read1 = regs[readAddress1];
`ifdef REGFILE_BYPASS_EN
      if (bypassActive && (readAddress1 == writeAddress)) begin
        read1 = writeData;
      end
`endif
    end
  end

  always_comb begin
    read2 = '0;
    if (readAddress2 != '0) begin
      read2 = regs[readAddress2];
`ifdef REGFILE_BYPASS_EN
      if (bypassActive && (readAddress2 == writeAddress)) begin
        read2 = writeData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values into a
// queue and raises sampleReq; the monitor pops and compares on the falling edge.
module tb_reg_file;

  logic        clock;
  logic        reset;
  logic        writeEnable;
  logic [4:0]  readAddress1;
  logic [4:0]  readAddress2;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic [31:0] read1;
  logic [31:0] read2;

  reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .writeEnable (writeEnable),
    .readAddress1(readAddress1),
    .readAddress2(readAddress2),
    .writeAddress(writeAddress),
    .writeData   (writeData),
    .read1       (read1),
    .read2       (read2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } expect_t;

  expect_t expQ[$];
  logic    sampleReq;
  int      checks;
  int      errors;

  // Monitor: compares both read ports whenever stimulus presents a sample.
  always @(negedge clock) begin
    if (sampleReq) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: sample with no expected entry");
      end else begin
        expect_t e;
        e = expQ.pop_front();
        checks++;
        if (read1 !== e.exp1) begin
          errors++;
          $display("FAIL %s read1: got %08h expected %08h", e.name, read1, e.exp1);
        end
        checks++;
        if (read2 !== e.exp2) begin
          errors++;
          $display("FAIL %s read2: got %08h expected %08h", e.name, read2, e.exp2);
        end
      end
    end
  end

  task automatic stepEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    writeEnable  = 1'b1;
    writeAddress = addr;
    writeData    = data;
    stepEdge();
    writeEnable  = 1'b0;
  endtask

  // Present a read pair for one cycle; the monitor checks it at the negedge.
  task automatic checkRead(input string name, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
    expect_t e;
    readAddress1 = a1;
    readAddress2 = a2;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    expQ.push_back(e);
    sampleReq = 1'b1;
    stepEdge();
    sampleReq = 1'b0;
  endtask

  initial begin
    expect_t e;
    logic [31:0] bypassExp;
    int budget;
    checks       = 0;
    errors       = 0;
    sampleReq    = 1'b0;
    reset        = 1'b1;
    writeEnable  = 1'b0;
    readAddress1 = '0;
    readAddress2 = '0;
    writeAddress = '0;
    writeData    = '0;

    // Reset clears everything.
    stepEdge();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checkRead("reset_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Register 0 ignores writes.
    writeReg(5'd0, 32'hFFFF_FFFF);
    checkRead("r0_protect", 5'd0, 5'd0, 32'h0, 32'h0);

    // Basic writes.
    writeReg(5'd1, 32'hFFFF_FFFF);
    writeReg(5'd2, 32'hFFFF_FFFF);
    writeReg(5'd3, 32'hFFFF_FFFF);
    checkRead("basic_r0_r1", 5'd0, 5'd1, 32'h0, 32'hFFFF_FFFF);
    checkRead("basic_r2_r3", 5'd2, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Write-enable gating.
    writeReg(5'd4, 32'h0001_0000);
    writeEnable  = 1'b0;
    writeAddress = 5'd5;
    writeData    = 32'hCAFE_F00D;
    stepEdge();
    stepEdge();
    checkRead("we_gating", 5'd4, 5'd5, 32'h0001_0000, 32'h0);

    // Distinct patterns, top address, back-to-back writes.
    writeReg(5'd10, 32'hDEAD_BEEF);
    writeReg(5'd31, 32'h1234_5678);
    checkRead("pattern_r10_r31", 5'd10, 5'd31, 32'hDEAD_BEEF, 32'h1234_5678);
    writeReg(5'd11, 32'h0000_0001);
    writeReg(5'd11, 32'h0000_0002);
    checkRead("back_to_back", 5'd11, 5'd11, 32'h0000_0002, 32'h0000_0002);

    // Reset overrides a simultaneous write.
    reset        = 1'b1;
    writeEnable  = 1'b1;
    writeAddress = 5'd7;
    writeData    = 32'h1234_5678;
    stepEdge();
    reset       = 1'b0;
    writeEnable = 1'b0;
    checkRead("reset_priority", 5'd7, 5'd1, 32'h0, 32'h0);
    checkRead("reset_clears", 5'd31, 5'd10, 32'h0, 32'h0);

    // Writes resume after reset.
    writeReg(5'd7, 32'h1357_9BDF);
    checkRead("post_reset_write", 5'd7, 5'd4, 32'h1357_9BDF, 32'h0);

    // Read during write to r9 (currently 0).
`ifdef REGFILE_BYPASS_EN
    bypassExp = 32'hA5A5_A5A5;
`else
    bypassExp = 32'h0;
`endif
    writeEnable  = 1'b1;
    writeAddress = 5'd9;
    writeData    = 32'hA5A5_A5A5;
    readAddress1 = 5'd9;
    readAddress2 = 5'd0;
    e.name = "rdw_before_edge";
    e.exp1 = bypassExp;
    e.exp2 = 32'h0;
    expQ.push_back(e);
    sampleReq = 1'b1;
    stepEdge();
    sampleReq   = 1'b0;
    writeEnable = 1'b0;
    checkRead("rdw_after_edge", 5'd9, 5'd0, 32'hA5A5_A5A5, 32'h0);

    // Drain the scoreboard within a bounded number of cycles.
    budget = 10;
    while (expQ.size() != 0 && budget > 0) begin
      stepEdge();
      budget--;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
